eic_nested: RTL

//  Parametrised external interrupt controller for MIPSfpga+ EIC mode, successor to the fixed 64-ch EIC.
//  Up to 255 channels; per-channel sense mode, mask and 4-bit priority; arbitration picks the highest priority.

---
 rtl/eic_nested_if.sv | 27 ++
 rtl/eic_nested.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/eic_nested_if.sv
// Register-bus, IRQ-pin and CPU EIC-port signals of the nested interrupt controller.
interface eic_nested_if #(
  parameter int CHANNELS = 64
);
  logic [CHANNELS-1:0] signal;
  logic [6:0]          read_addr;
  logic [31:0]         read_data;
  logic [6:0]          write_addr;
  logic [31:0]         write_data;
  logic                write_enable;
  logic                int_ack;
  logic                int_eoi;
  logic [17:1]         EIC_Offset;
  logic [3:0]          EIC_ShadowSet;
  logic [7:0]          EIC_Interrupt;
  logic [5:0]          EIC_Vector;

  modport master (
    output signal, read_addr, write_addr, write_data, write_enable, int_ack, int_eoi,
    input  read_data, EIC_Offset, EIC_ShadowSet, EIC_Interrupt, EIC_Vector
  );

  modport slave (
    input  signal, read_addr, write_addr, write_data, write_enable, int_ack, int_eoi,
    output read_data, EIC_Offset, EIC_ShadowSet, EIC_Interrupt, EIC_Vector
  );
endinterface

// File: rtl/eic_nested.sv
// Nested external interrupt controller for the MIPSfpga+ EIC port: per-channel sense,
// mask and 4-bit priority, highest-priority arbitration and an ack/EOI in-service stack
// so that only strictly higher priorities preempt the running handler.
module eic_nested #(
  parameter int CHANNELS   = 64,
  parameter int NEST_DEPTH = 4
) (
  input logic         CLK,
  input logic         RESET,
  eic_nested_if.slave bus
);

  localparam int         PAD       = 256;
  localparam int         CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int         SW        = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
  localparam logic [7:0] CH_LIMIT  = 8'(CHANNELS);
  localparam logic [3:0] DEPTH_MAX = 4'(NEST_DEPTH);
  localparam logic [PAD-1:0] BANK_ONES = {{(PAD-32){1'b0}}, 32'hFFFF_FFFF};

  logic                enable, underflow;
  logic [3:0]          level, depth;
  logic [3:0]          stack [NEST_DEPTH];
  logic [CHANNELS-1:0] mask, flag, sense_lo, sense_hi, h1, h0;
  logic [3:0]          prio [CHANNELS];
  logic [7:0]          prio_idx;
  logic [1:0]          warm;
  logic [7:0]          pres_ch;
  logic [3:0]          pres_prio;

  logic [3:0]          wgroup, rgroup;
  logic [2:0]          wbank, rbank;
  logic [CHANNELS-1:0] wsel, wdat, hit, sw_set, sw_clr, ack_clr;
  logic [7:0]          arb_ch;
  logic [3:0]          arb_prio;
  logic                ack_taken, eoi, pop, full, prio_idx_ok, wr_ctrl;
  logic [31:0]         rd;

  assign wgroup      = bus.write_addr[6:3];
  assign wbank       = bus.write_addr[2:0];
  assign rgroup      = bus.read_addr[6:3];
  assign rbank       = bus.read_addr[2:0];
  assign wsel        = CHANNELS'(BANK_ONES << {wbank, 5'd0});
  assign wdat        = CHANNELS'({{(PAD-32){1'b0}}, bus.write_data} << {wbank, 5'd0});
  assign wr_ctrl     = bus.write_enable && (wgroup == 4'd0) && (wbank == 3'd0);
  assign ack_taken   = bus.int_ack && (pres_ch != 8'd0);
  assign eoi         = bus.int_eoi || (bus.write_enable && (wgroup == 4'd8) && (wbank == 3'd2));
  assign pop         = eoi && (depth != 4'd0);
  assign full        = (depth == DEPTH_MAX);
  assign prio_idx_ok = (prio_idx < CH_LIMIT);

  // Returns the 32-channel slice of a per-channel vector, zero above CHANNELS.
  function automatic logic [31:0] bank_word(input logic [CHANNELS-1:0] v, input logic [2:0] b);
    logic [PAD-1:0] p;
    p = '0;
    p[CHANNELS-1:0] = v;
    return p[{b, 5'd0} +: 32];
  endfunction

  // Sense detection from the two-flop pin history, held off until the history is valid.
  always_comb begin
    hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case ({sense_hi[i], sense_lo[i]})
        2'b00:   hit[i] = h0[i];
        2'b01:   hit[i] = h1[i] ^ h0[i];
        2'b10:   hit[i] = h1[i] & ~h0[i];
        default: hit[i] = ~h1[i] & h0[i];
      endcase
    end
    if (warm != 2'd2) hit = '0;
  end

  // Software set/clear masks from FLAG, FLAG_SET and FLAG_CLR writes plus the ack clear.
  always_comb begin
    sw_set  = '0;
    sw_clr  = '0;
    ack_clr = '0;
    if (bus.write_enable) begin
      case (wgroup)
        4'd2: begin
          sw_set = wsel & wdat;
          sw_clr = wsel & ~wdat;
        end
        4'd3: sw_set = wsel & wdat;
        4'd4: sw_clr = wsel & wdat;
        default: ;
      endcase
    end
    for (int i = 0; i < CHANNELS; i++) ack_clr[i] = ack_taken && (pres_ch == 8'(i + 1));
  end

  // Highest eligible priority wins; strict compare keeps the lowest index on ties.
  always_comb begin
    arb_ch   = '0;
    arb_prio = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (enable && flag[i] && mask[i] && (prio[i] > level) && (prio[i] > arb_prio)) begin
        arb_ch   = 8'(i + 1);
        arb_prio = prio[i];
      end
    end
  end

  // Combinational register read-back.
  always_comb begin
    rd = '0;
    case (rgroup)
      4'd0: if (rbank == 3'd0) rd = {15'd0, underflow, depth, level, 7'd0, enable};
      4'd1: rd = bank_word(mask, rbank);
      4'd2,
      4'd3: rd = bank_word(flag, rbank);
      4'd5: rd = bank_word(sense_lo, rbank);
      4'd6: rd = bank_word(sense_hi, rbank);
      4'd7: rd = bank_word(bus.signal, rbank);
      4'd8: begin
        if (rbank == 3'd0) rd = {24'd0, prio_idx};
        else if (rbank == 3'd1 && prio_idx_ok) rd = {28'd0, prio[CW'(prio_idx)]};
      end
      default: ;
    endcase
  end

  // Pin history and the warm-up counter that masks the first two cycles after reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      h0   <= '0;
      h1   <= '0;
      warm <= '0;
    end else begin
      h0 <= bus.signal;
      h1 <= h0;
      if (warm != 2'd2) warm <= warm + 2'd1;
    end
  end

  // Configuration registers: enable, underflow sticky, mask, sense modes and priorities.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      enable    <= 1'b0;
      underflow <= 1'b0;
      mask      <= '0;
      sense_lo  <= '0;
      sense_hi  <= '0;
      prio_idx  <= '0;
      for (int i = 0; i < CHANNELS; i++) prio[i] <= '0;
    end else begin
      if (wr_ctrl) enable <= bus.write_data[0];
      if (eoi && depth == 4'd0) underflow <= 1'b1;
      else if (wr_ctrl && bus.write_data[16]) underflow <= 1'b0;
      if (bus.write_enable) begin
        case (wgroup)
          4'd1: mask     <= (mask & ~wsel) | (wdat & wsel);
          4'd5: sense_lo <= (sense_lo & ~wsel) | (wdat & wsel);
          4'd6: sense_hi <= (sense_hi & ~wsel) | (wdat & wsel);
          4'd8: begin
            if (wbank == 3'd0) prio_idx <= bus.write_data[7:0];
            else if (wbank == 3'd1 && prio_idx_ok) prio[CW'(prio_idx)] <= bus.write_data[3:0];
          end
          default: ;
        endcase
      end
    end
  end

  // Pending flags: a hardware hit beats a same-cycle software or ack clear.
  always_ff @(posedge CLK) begin
    if (RESET) flag <= '0;
    else       flag <= (flag & ~sw_clr & ~ack_clr) | sw_set | (mask & hit);
  end

  // In-service stack: EOI pops into level, ack pushes level; both together only swap level.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      level <= '0;
      depth <= '0;
      for (int i = 0; i < NEST_DEPTH; i++) stack[i] <= '0;
    end else if (pop && ack_taken) begin
      level <= pres_prio;
    end else if (pop) begin
      level <= stack[SW'(depth - 4'd1)];
      depth <= depth - 4'd1;
    end else if (ack_taken) begin
      stack[SW'(depth)] <= level;
      depth             <= depth + 4'd1;
      level             <= pres_prio;
    end
  end

  // Registered presentation; blanked for a cycle after an ack and while the stack is full.
  always_ff @(posedge CLK) begin
    if (RESET || ack_taken || full) begin
      pres_ch   <= '0;
      pres_prio <= '0;
    end else begin
      pres_ch   <= arb_ch;
      pres_prio <= arb_prio;
    end
  end

  assign bus.read_data     = rd;
  assign bus.EIC_Offset    = '0;
  assign bus.EIC_ShadowSet = pres_prio;
  assign bus.EIC_Interrupt = pres_ch;
  assign bus.EIC_Vector    = pres_ch[5:0];

endmodule
